seq_counter: RTL and testbench
==============================

SEQ_COUNTER -- requirements
Module: seq_counter

Interface
REQ-001 SHALL expose parameter WIDTH, default 4: counter width in bits, legal range 1..32.
REQ-002 SHALL expose parameter MAX, default 2**WIDTH-1: terminal value, legal range 1..2**WIDTH-1.
REQ-003 SHALL expose parameter PRESCALE, default 1: enabled cycles per step, legal range 1..65536 (used only with PRESCALE_EN).
REQ-004 SHALL provide port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL provide port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL provide port en, input, 1 bit: count enable.
REQ-007 SHALL provide port load, input, 1 bit: synchronous parallel load strobe.
REQ-008 SHALL provide port load_val, input, WIDTH bits: value to load.
REQ-009 SHALL provide port dir, input, 1 bit: 1 = count up, 0 = count down.
REQ-010 SHALL provide port sat, input, 1 bit: 1 = saturate at limits, 0 = wrap.
REQ-011 SHALL provide port out, output, WIDTH bits: registered count.
REQ-012 SHALL provide port tc, output, 1 bit: registered one-cycle wrap pulse.
REQ-013 SHALL provide port ovf, output, 1 bit: registered sticky saturation flag.

Function
REQ-014 Priority SHALL be rst > load > step; at most one action per cycle.
REQ-015 On load, out SHALL take min(load_val, MAX) on the next edge; the prescaler and ovf SHALL clear; tc SHALL be 0.
REQ-016 A "step" SHALL occur on a cycle with en=1, load=0, rst=0 (and a prescaler tick when PRESCALE_EN is defined).
REQ-017 Up step with out<MAX: out SHALL become out+1; down step with out>0: out SHALL become out-1.
REQ-018 Up step at out==MAX with sat=0: out SHALL become 0 and tc SHALL be 1 in the same cycle that out shows 0.
REQ-019 Down step at out==0 with sat=0: out SHALL become MAX and tc SHALL be 1 in the same cycle that out shows MAX.
REQ-020 Step at a limit with sat=1: out SHALL hold, tc SHALL stay 0, and ovf SHALL set and remain set until load or rst.
REQ-021 tc SHALL be 0 on every cycle not immediately following a wrap step; consecutive wraps (MAX=1, sat=0) SHALL give tc=1 on consecutive cycles.
REQ-022 en=0 SHALL hold out, ovf and the prescaler state; tc SHALL drop to 0.
REQ-023 dir and sat SHALL be sampled each cycle; a change SHALL take effect on the next step without glitching out.
REQ-024 All arithmetic SHALL be performed modulo the range 0..MAX; out SHALL never exceed MAX.

Reset
REQ-025 When rst=1 at an edge, out SHALL become 0, tc 0, ovf 0, and the prescaler 0, regardless of en and load.
REQ-026 rst asserted mid-count or mid-prescale SHALL discard the partial prescale; the first step after release SHALL require a full PRESCALE enabled cycles.

Configuration
REQ-027 With macro SEQ_COUNTER_PRESCALE_EN defined, an internal prescaler SHALL count enabled cycles 0..PRESCALE-1, and a step SHALL occur only on the enabled cycle where the prescaler equals PRESCALE-1, after which the prescaler returns to 0.
REQ-028 Without SEQ_COUNTER_PRESCALE_EN, no prescaler logic SHALL be generated, every enabled cycle SHALL be a step, and PRESCALE SHALL be ignored.

Verification
REQ-029 WIDTH=4, MAX=9, dir=1, sat=0, en=1 for 12 cycles after rst -> out 1..9,0,1,2; tc=1 only in the cycle out shows 0.
REQ-030 MAX=9, load with load_val=13 -> out=9 next cycle; then down-count with sat=1 from 1 -> out 0, then holds at 0, ovf=1 and stays 1 until the next load.
REQ-031 load=1 and en=1 in the same cycle with load_val=5 -> out=5 with no step applied; rst=1 with load=1 -> out=0.
REQ-032 SEQ_COUNTER_PRESCALE_EN, PRESCALE=3, en=1 continuously -> out increments every 3rd cycle; en pulsed low for 2 cycles mid-prescale -> step is delayed by exactly 2 cycles.
REQ-033 MAX=1, sat=0, dir=1, en=1 -> out toggles 1,0,1,0 with tc=1 every second cycle; flipping dir mid-run takes effect on the next step.

Source files
------------

// File: rtl/seq_counter.sv
// Up/down counter with terminal value MAX, wrap or saturate, load and a wrap pulse.
// Optional enable prescaler is built only when SEQ_COUNTER_PRESCALE_EN is defined.
module seq_counter #(
  parameter int                WIDTH    = 4,
  parameter logic [WIDTH-1:0]  MAX      = {WIDTH{1'b1}},
  parameter int                PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic             sat,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             ovf
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("seq_counter: WIDTH out of range");
  end
  if (MAX == '0) begin : g_bad_max
    $error("seq_counter: MAX must be at least 1");
  end
  if (PRESCALE < 1 || PRESCALE > 65536) begin : g_bad_prescale
    $error("seq_counter: PRESCALE out of range");
  end

  logic [WIDTH-1:0] out_q, out_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             step;

`ifdef SEQ_COUNTER_PRESCALE_EN
  localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);
  logic [15:0] ps_q, ps_d;

  // Prescaler only advances on enabled, non-load cycles; a load discards it.
  always_comb begin
    ps_d = ps_q;
    step = 1'b0;
    if (load) begin
      ps_d = '0;
    end else if (en) begin
      if (ps_q == PS_LAST) begin
        ps_d = '0;
        step = 1'b1;
      end else begin
        ps_d = ps_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ps_q <= '0;
    else     ps_q <= ps_d;
  end
`else
  assign step = en && !load;
`endif

  always_comb begin
    out_d = out_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    if (load) begin
      out_d = (load_val > MAX) ? MAX : load_val;
      ovf_d = 1'b0;
    end else if (step) begin
      if (dir) begin
        if (out_q != MAX)  out_d = out_q + 1'b1;
        else if (sat)      ovf_d = 1'b1;
        else begin
          out_d = '0;
          tc_d  = 1'b1;
        end
      end else begin
        if (out_q != '0)   out_d = out_q - 1'b1;
        else if (sat)      ovf_d = 1'b1;
        else begin
          out_d = MAX;
          tc_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      out_q <= out_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign out = out_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_seq_counter.sv
// Directed bench for seq_counter: MAX=9 and MAX=1 instances, plus a PRESCALE=3
// instance when SEQ_COUNTER_PRESCALE_EN is defined.
module tb_seq_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;
  logic       dir = 1'b1;
  logic       sat = 1'b0;

  logic [3:0] out_a, out_b;
  logic       tc_a, tc_b, ovf_a, ovf_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_counter #(.WIDTH(4), .MAX(4'd9)) u_a (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .dir(dir), .sat(sat), .out(out_a), .tc(tc_a), .ovf(ovf_a)
  );

  seq_counter #(.WIDTH(4), .MAX(4'd1)) u_b (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .dir(dir), .sat(sat), .out(out_b), .tc(tc_b), .ovf(ovf_b)
  );

`ifdef SEQ_COUNTER_PRESCALE_EN
  logic [3:0] out_c;
  logic       tc_c, ovf_c;
  seq_counter #(.WIDTH(4), .PRESCALE(3)) u_c (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .dir(dir), .sat(sat), .out(out_c), .tc(tc_c), .ovf(ovf_c)
  );
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    if (obs !== want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, want);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    tick();
    check("rst_out", out_a, 0);
    check("rst_tc", tc_a, 0);
    check("rst_ovf", ovf_a, 0);

    // Up count MAX=9 with wrap: 1..9,0,1,2
    rst = 0; en = 1; dir = 1; sat = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check($sformatf("up_out_%0d", i), out_a, i % 10);
      check($sformatf("up_tc_%0d", i), tc_a, (i == 10) ? 1 : 0);
    end

    // Load above MAX clamps
    load = 1; load_val = 4'd13;
    tick();
    check("load_clamp", out_a, 9);
    check("load_tc", tc_a, 0);

    // Down count with saturation from 1
    load_val = 4'd1;
    tick();
    check("load_1", out_a, 1);
    load = 0; dir = 0; sat = 1;
    tick();
    check("sat_dn_out0", out_a, 0);
    check("sat_dn_ovf0", ovf_a, 0);
    tick();
    check("sat_hold_out", out_a, 0);
    check("sat_hold_ovf", ovf_a, 1);
    check("sat_hold_tc", tc_a, 0);
    tick();
    check("sat_hold2_ovf", ovf_a, 1);
    en = 0;
    tick();
    check("en0_ovf", ovf_a, 1);
    check("en0_out", out_a, 0);
    load = 1; load_val = 4'd4;
    tick();
    check("load_clr_ovf", ovf_a, 0);
    check("load_4", out_a, 4);

    // Down wrap from 0 to MAX
    load_val = 4'd0;
    tick();
    load = 0; en = 1; sat = 0;
    tick();
    check("dn_wrap_out", out_a, 9);
    check("dn_wrap_tc", tc_a, 1);
    tick();
    check("dn_out8", out_a, 8);
    check("dn_tc0", tc_a, 0);
    en = 0;
    tick();
    check("en0_hold", out_a, 8);

    // Load beats step; rst beats load
    load = 1; en = 1; dir = 1; load_val = 4'd5;
    tick();
    check("load_pri", out_a, 5);
    rst = 1;
    tick();
    check("rst_pri", out_a, 0);

    // Up saturation at MAX, then rst clears ovf
    rst = 0; load = 1; load_val = 4'd9;
    tick();
    load = 0; sat = 1; dir = 1; en = 1;
    tick();
    check("sat_up_out", out_a, 9);
    check("sat_up_ovf", ovf_a, 1);
    check("sat_up_tc", tc_a, 0);
    rst = 1;
    tick();
    check("rst_clr_ovf", ovf_a, 0);

    // MAX=1 toggling with wrap pulses, then dir flip
    rst = 0; sat = 0; dir = 1; en = 1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("m1_out_%0d", i), out_b, i % 2);
      check($sformatf("m1_tc_%0d", i), tc_b, (i % 2 == 0) ? 1 : 0);
    end
    dir = 0;
    tick();
    check("m1_dn_wrap_out", out_b, 1);
    check("m1_dn_wrap_tc", tc_b, 1);
    tick();
    check("m1_dn_out", out_b, 0);
    check("m1_dn_tc", tc_b, 0);

`ifdef SEQ_COUNTER_PRESCALE_EN
    begin
      logic       en_tab  [10] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1};
      logic [3:0] want_tab[10] = '{0, 0, 1, 1, 1, 1, 1, 2, 2, 2};
      rst = 1; en = 0; dir = 1; sat = 0; load = 0;
      tick();
      rst = 0;
      for (int i = 0; i < 10; i++) begin
        en = en_tab[i];
        tick();
        check($sformatf("ps_out_%0d", i), out_c, want_tab[i]);
      end
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
